shift_seq_8b: RTL and testbench

SHIFT_SEQ_8B -- requirements
Module: shift_seq_8b

---
 rtl/shift_seq_8b.sv | 88 ++++++++
 tb/tb_shift_seq_8b.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_8b.sv
// Multi-cycle shifter: one 1-bit step of the latched operation per clock,
// with a busy/done handshake and a result register that holds until the next start.
module shift_seq_8b #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   datain,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dataout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             r_state;
    op_t                r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_step;

    always_comb begin
        w_step = r_data;
        case (r_op)
            OP_LSL:  w_step = {r_data[WIDTH-2:0], 1'b0};
            OP_LSR:  w_step = {1'b0, r_data[WIDTH-1:1]};
            OP_ASR:  w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            OP_ROR:  w_step = {r_data[0], r_data[WIDTH-1:1]};
            default: w_step = r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= OP_LSL;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data  <= datain;
                        r_op    <= op_t'(op);
                        r_cnt   <= shamt;
                        r_state <= (shamt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - CNT_ONE;
                    // Leave on the 1->0 step so the counter never wraps.
                    if (r_cnt == CNT_ONE) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == SHIFT);
    assign done    = (r_state == DONE);
    assign dataout = r_data;

endmodule

// File: tb/tb_shift_seq_8b.sv
// Directed self-checking bench for shift_seq_8b: per-scenario tasks with
// hand-computed results and cycle-exact busy/done timing.
module tb_shift_seq_8b;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] datain;
    logic [2:0] shamt;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic [7:0] dataout;

    int checks;
    int errors;

    shift_seq_8b #(
        .WIDTH  (8),
        .SHAMT_W(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .datain (datain),
        .shamt  (shamt),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .dataout(dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] o;
        logic [2:0] n;
        logic [7:0] exp;
    } vec_t;

    // Present one start request and step past the accepting edge.
    task automatic issue(input logic [7:0] d, input logic [1:0] o, input logic [2:0] n);
        datain = d;
        op     = o;
        shamt  = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        datain = 8'h5A;
        shamt = 3'd2;
        op    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataout !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dataout=%h, expected 0 0 00", busy, done, dataout);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataout !== 8'h00) begin
            errors++;
            $display("FAIL start_with_rst: busy=%b done=%b dataout=%h, expected 0 0 00", busy, done, dataout);
        end
    endtask

    task automatic test_ops();
        vec_t v[5];
        v[0] = '{8'h96, 2'b00, 3'd3, 8'hB0};
        v[1] = '{8'h96, 2'b10, 3'd2, 8'hE5};
        v[2] = '{8'h96, 2'b01, 3'd7, 8'h01};
        v[3] = '{8'h96, 2'b11, 3'd1, 8'h4B};
        v[4] = '{8'h96, 2'b11, 3'd0, 8'h96};
        for (int i = 0; i < 5; i++) begin
            issue(v[i].d, v[i].o, v[i].n);
            datain = 8'h00;
            shamt  = 3'd6;
            op     = 2'b01;
            for (int k = 0; k < int'(v[i].n); k++) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL op%0d_busy_edge%0d: busy=%b done=%b, expected 1 0", i, k, busy, done);
                end
                @(posedge clk);
                #1;
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || dataout !== v[i].exp) begin
                errors++;
                $display("FAIL op%0d_result: done=%b busy=%b dataout=%h, expected 1 0 %h",
                         i, done, busy, dataout, v[i].exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || dataout !== v[i].exp) begin
                errors++;
                $display("FAIL op%0d_hold: done=%b busy=%b dataout=%h, expected 0 0 %h",
                         i, done, busy, dataout, v[i].exp);
            end
        end
    endtask

    task automatic test_start_while_busy();
        issue(8'h96, 2'b00, 3'd3);
        datain = 8'hFF;
        shamt  = 3'd5;
        op     = 2'b11;
        start  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL busy_ignore_edge%0d: busy=%b done=%b, expected 1 0", k, busy, done);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || dataout !== 8'hB0) begin
            errors++;
            $display("FAIL busy_ignore_result: done=%b dataout=%h, expected 1 b0", done, dataout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_busy;
        logic [4:0] exp_done;
        logic [7:0] exp_dout [5];
        exp_busy = 5'b01001;
        exp_done = 5'b10010;
        exp_dout = '{8'h96, 8'h2C, 8'h2C, 8'h01, 8'h02};
        datain = 8'h96;
        op     = 2'b00;
        shamt  = 3'd1;
        start  = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            datain = 8'h01;
            checks++;
            if (busy !== exp_busy[e] || done !== exp_done[e] || dataout !== exp_dout[e]) begin
                errors++;
                $display("FAIL b2b_edge%0d: busy=%b done=%b dataout=%h, expected %b %b %h",
                         e, busy, done, dataout, exp_busy[e], exp_done[e], exp_dout[e]);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataout !== 8'h02) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b done=%b dataout=%h, expected 0 0 02", busy, done, dataout);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        issue(8'h96, 2'b00, 3'd5);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataout !== 8'h00) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b dataout=%h, expected 0 0 00", busy, done, dataout);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_done: active_cycles=%0d, expected 0", pulses);
        end
        issue(8'h96, 2'b01, 3'd2);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_abort_busy: busy=%b done=%b, expected 1 0", busy, done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || dataout !== 8'h25) begin
            errors++;
            $display("FAIL post_abort_result: done=%b dataout=%h, expected 1 25", done, dataout);
        end
        @(posedge clk);
        #1;
        // Reset landing in DONE after a zero-length operation.
        issue(8'h3C, 2'b00, 3'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dataout !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_done: busy=%b done=%b dataout=%h, expected 0 0 00", busy, done, dataout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        datain = 8'h00;
        shamt  = 3'd0;
        op     = 2'b00;
        test_reset();
        test_ops();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
